// File: rtl/fpu_divsqrt_pkg.sv
// Shared definitions for the recoded-F64 divide/sqrt issue/writeback controller.
//   state_t    controller state encoding
//   REC_F64_W  width of a recoded F64 value (sign + 12-bit exponent + 52-bit fraction)
//   EXC_W      width of the exception flag vector {invalid, infinite, overflow, underflow, inexact}
//   RM_W       width of the rounding-mode field
package fpu_divsqrt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    KILLED,
    HOLD
  } state_t;

  localparam int REC_F64_W = 65;
  localparam int EXC_W     = 5;
  localparam int RM_W      = 3;

endpackage

// File: rtl/div_sqrt_rec_f64_ctrl.sv
// Issue/writeback controller for the recoded-F64 divide/sqrt unit (DivSqrtRecF64).
// Forwards one tagged request to the unit, pairs the untagged result with the
// stored tag and holds it until writeback accepts. Single outstanding operation.
//
// Ports
//   clock, reset                  sole clock; synchronous active-high reset
//   req_valid/req_ready           request handshake (fire = valid & ready)
//   req_sqrt, req_a, req_b,
//   req_rm, req_tag               request payload (1 = sqrt(a), 0 = a/b)
//   kill                          squash the current / in-flight operation
//   ds_inValid, ds_sqrtOp, ds_a,
//   ds_b, ds_roundingMode,
//   ds_detectTininess             issue side towards the unit
//   ds_inReady_div/_sqrt          unit ready per operation flavour
//   ds_outValid_div/_sqrt         unit single-cycle result strobes
//   ds_out, ds_exceptionFlags     unit result and flags
//   resp_valid/resp_ready         writeback handshake
//   resp_data, resp_exc, resp_tag held result, flags and destination tag
//   busy                          controller not idle
//   err                           sticky protocol error, cleared only by reset
module div_sqrt_rec_f64_ctrl
  import fpu_divsqrt_pkg::*;
#(
  parameter int TAG_W           = 5,
  parameter int DETECT_TININESS = 1,
  parameter int TIMEOUT         = 127
) (
  input  logic                 clock,
  input  logic                 reset,

  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_sqrt,
  input  logic [REC_F64_W-1:0] req_a,
  input  logic [REC_F64_W-1:0] req_b,
  input  logic [RM_W-1:0]      req_rm,
  input  logic [TAG_W-1:0]     req_tag,
  input  logic                 kill,

  output logic                 ds_inValid,
  output logic                 ds_sqrtOp,
  output logic [REC_F64_W-1:0] ds_a,
  output logic [REC_F64_W-1:0] ds_b,
  output logic [RM_W-1:0]      ds_roundingMode,
  output logic                 ds_detectTininess,
  input  logic                 ds_inReady_div,
  input  logic                 ds_inReady_sqrt,
  input  logic                 ds_outValid_div,
  input  logic                 ds_outValid_sqrt,
  input  logic [REC_F64_W-1:0] ds_out,
  input  logic [EXC_W-1:0]     ds_exceptionFlags,

  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [REC_F64_W-1:0] resp_data,
  output logic [EXC_W-1:0]     resp_exc,
  output logic [TAG_W-1:0]     resp_tag,

  output logic                 busy,
  output logic                 err
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

  state_t               state;
  state_t               stateNext;
  logic                 opSqrt;
  logic [TAG_W-1:0]     tagReg;
  logic [TMR_W-1:0]     timer;
  logic [REC_F64_W-1:0] dataReg;
  logic [EXC_W-1:0]     excReg;
  logic [TAG_W-1:0]     respTagReg;
  logic                 errReg;

  logic isIdle;
  logic inFlight;
  logic fire;
  logic done;
  logic capture;
  logic errSet;

  assign isIdle   = (state == IDLE);
  assign inFlight = (state == WAIT) || (state == KILLED);
  assign done     = ds_outValid_div | ds_outValid_sqrt;

  // Issue is a pure pass-through; only the valid is qualified.
  assign req_ready         = isIdle & ~kill & (req_sqrt ? ds_inReady_sqrt : ds_inReady_div);
  assign fire              = req_valid & req_ready;
  assign ds_inValid        = req_valid & isIdle & ~kill;
  assign ds_sqrtOp         = req_sqrt;
  assign ds_a              = req_a;
  assign ds_b              = req_b;
  assign ds_roundingMode   = req_rm;
  assign ds_detectTininess = 1'(DETECT_TININESS);

  always_comb begin
    stateNext = state;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (fire) stateNext = WAIT;
      end
      WAIT: begin
        if (done) begin
          if (kill) begin
            stateNext = IDLE;
          end else begin
            stateNext = HOLD;
            capture   = 1'b1;
          end
        end else if (kill) begin
          stateNext = KILLED;
        end
      end
      // The unit cannot be cancelled: a killed op still waits for its done.
      KILLED: begin
        if (done) stateNext = IDLE;
      end
      HOLD: begin
        if (kill || resp_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    errSet = 1'b0;
    if (done && (isIdle || (state == HOLD))) errSet = 1'b1;
    if (ds_outValid_div && opSqrt)           errSet = 1'b1;
    if (ds_outValid_sqrt && !opSqrt)         errSet = 1'b1;
    if (ds_outValid_div && ds_outValid_sqrt) errSet = 1'b1;
    if (inFlight && (timer == TMR_MAX))      errSet = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      opSqrt     <= 1'b0;
      tagReg     <= '0;
      timer      <= '0;
      dataReg    <= '0;
      excReg     <= '0;
      respTagReg <= '0;
      errReg     <= 1'b0;
    end else begin
      state <= stateNext;
      if (fire) begin
        tagReg <= req_tag;
        opSqrt <= req_sqrt;
        timer  <= '0;
      end else if (inFlight && (timer != TMR_MAX)) begin
        timer <= timer + 1'b1;
      end
      if (capture) begin
        dataReg    <= ds_out;
        excReg     <= ds_exceptionFlags;
        respTagReg <= tagReg;
      end
      errReg <= errReg | errSet;
    end
  end

  assign resp_valid = (state == HOLD);
  assign resp_data  = dataReg;
  assign resp_exc   = excReg;
  assign resp_tag   = respTagReg;
  assign busy       = ~isIdle;
  assign err        = errReg;

endmodule

// File: tb/tb_div_sqrt_rec_f64_ctrl.sv
// Bench for div_sqrt_rec_f64_ctrl. A behavioural stand-in for DivSqrtRecF64
// lives inside the bench: it accepts one op, waits a programmable latency and
// strobes the matching outValid with a result from a small operand table.
module tb_div_sqrt_rec_f64_ctrl;

  localparam int TAG_W   = 5;
  localparam int TIMEOUT = 20;

  localparam logic [64:0] REC0  = {1'b0, 12'h000, 52'h0};
  localparam logic [64:0] REC1  = {1'b0, 12'h800, 52'h0};
  localparam logic [64:0] RECM1 = {1'b1, 12'h800, 52'h0};
  localparam logic [64:0] REC2  = {1'b0, 12'h801, 52'h0};
  localparam logic [64:0] REC3  = {1'b0, 12'h801, 52'h8000000000000};
  localparam logic [64:0] REC6  = {1'b0, 12'h802, 52'h8000000000000};
  localparam logic [64:0] RINF  = {1'b0, 12'hC00, 52'h0};
  localparam logic [64:0] QNAN  = {1'b0, 12'hE00, 52'h8000000000000};

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_sqrt = 1'b0;
  logic [64:0]       req_a = '0;
  logic [64:0]       req_b = '0;
  logic [2:0]        req_rm = '0;
  logic [TAG_W-1:0]  req_tag = '0;
  logic              kill = 1'b0;
  logic              ds_inValid;
  logic              ds_sqrtOp;
  logic [64:0]       ds_a;
  logic [64:0]       ds_b;
  logic [2:0]        ds_roundingMode;
  logic              ds_detectTininess;
  logic              ds_inReady_div;
  logic              ds_inReady_sqrt;
  logic              ds_outValid_div;
  logic              ds_outValid_sqrt;
  logic [64:0]       ds_out;
  logic [4:0]        ds_exceptionFlags;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [64:0]       resp_data;
  logic [4:0]        resp_exc;
  logic [TAG_W-1:0]  resp_tag;
  logic              busy;
  logic              err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  div_sqrt_rec_f64_ctrl #(.TAG_W(TAG_W), .DETECT_TININESS(1), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_sqrt(req_sqrt),
    .req_a(req_a), .req_b(req_b), .req_rm(req_rm), .req_tag(req_tag), .kill(kill),
    .ds_inValid(ds_inValid), .ds_sqrtOp(ds_sqrtOp), .ds_a(ds_a), .ds_b(ds_b),
    .ds_roundingMode(ds_roundingMode), .ds_detectTininess(ds_detectTininess),
    .ds_inReady_div(ds_inReady_div), .ds_inReady_sqrt(ds_inReady_sqrt),
    .ds_outValid_div(ds_outValid_div), .ds_outValid_sqrt(ds_outValid_sqrt),
    .ds_out(ds_out), .ds_exceptionFlags(ds_exceptionFlags),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_exc(resp_exc), .resp_tag(resp_tag), .busy(busy), .err(err)
  );

  // ---------------- unit stand-in ----------------
  function automatic logic [69:0] unitResult(input logic [64:0] a, input logic [64:0] b,
                                             input logic sq);
    if (!sq && a == REC6 && b == REC2) return {REC3, 5'b00000};
    if (sq && a == RECM1)              return {QNAN, 5'b10000};
    if (!sq && b == REC0)              return {RINF, 5'b01000};
    return {a ^ {b[31:0], b[64:32]} ^ {64'b0, sq}, a[4:0] ^ b[9:5]};
  endfunction

  logic        stubPending = 1'b0;
  logic        stubSq = 1'b0;
  int          stubCnt = 0;
  int          stubLat = 2;
  logic        stubHang = 1'b0;
  logic        stubSwap = 1'b0;
  logic        forceOvSqrt = 1'b0;
  logic        stubOvDiv = 1'b0;
  logic        stubOvSqrt = 1'b0;
  logic [64:0] stubOut = '0;
  logic [4:0]  stubExc = '0;

  assign ds_inReady_div    = ~stubPending;
  assign ds_inReady_sqrt   = ~stubPending;
  assign ds_outValid_div   = stubOvDiv;
  assign ds_outValid_sqrt  = stubOvSqrt | forceOvSqrt;
  assign ds_out            = stubOut;
  assign ds_exceptionFlags = stubExc;

  always @(posedge clock) begin
    stubOvDiv  <= 1'b0;
    stubOvSqrt <= 1'b0;
    if (reset) begin
      stubPending <= 1'b0;
      stubCnt     <= 0;
    end else if (!stubPending) begin
      if (ds_inValid) begin
        stubPending          <= 1'b1;
        stubCnt              <= stubLat;
        stubSq               <= ds_sqrtOp;
        {stubOut, stubExc}   <= unitResult(ds_a, ds_b, ds_sqrtOp);
      end
    end else if (!stubHang) begin
      if (stubCnt == 0) begin
        stubPending <= 1'b0;
        if (stubSq ^ stubSwap) stubOvSqrt <= 1'b1;
        else                   stubOvDiv  <= 1'b1;
      end else begin
        stubCnt <= stubCnt - 1;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Present a request and hold it until accepted (bounded).
  task automatic issue(input logic [64:0] a, input logic [64:0] b, input logic sq,
                       input logic [2:0] rm, input logic [TAG_W-1:0] tg);
    int n;
    n = 0;
    req_valid = 1'b1; req_a = a; req_b = b; req_sqrt = sq; req_rm = rm; req_tag = tg;
    #1;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    check("issue_accept", {64'b0, req_ready}, 65'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic waitResp(input int budget);
    int n;
    n = 0;
    while (!resp_valid && n < budget) begin
      step();
      n++;
    end
    check("resp_arrives", {64'b0, resp_valid}, 65'd1);
  endtask

  task automatic checkResp(input string tag, input logic [64:0] d, input logic [4:0] x,
                           input logic [TAG_W-1:0] tg);
    check({tag, "_data"}, resp_data, d);
    check({tag, "_exc"}, {60'b0, resp_exc}, {60'b0, x});
    check({tag, "_tag"}, {60'b0, resp_tag}, {60'b0, tg});
  endtask

  task automatic checkResetState(input string tag);
    check({tag, "_resp_valid"}, {64'b0, resp_valid}, 65'd0);
    check({tag, "_resp_data"}, resp_data, 65'd0);
    check({tag, "_resp_exc"}, {60'b0, resp_exc}, 65'd0);
    check({tag, "_resp_tag"}, {60'b0, resp_tag}, 65'd0);
    check({tag, "_busy"}, {64'b0, busy}, 65'd0);
    check({tag, "_err"}, {64'b0, err}, 65'd0);
    check({tag, "_req_ready"}, {64'b0, req_ready}, 65'd1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int sawResp;
    int n;
    logic [64:0] ra, rb;
    logic        rs;
    logic [TAG_W-1:0] rt;
    logic [69:0] ex;
    int d;

    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step();
    checkResetState("reset");
    check("tininess", {64'b0, ds_detectTininess}, 65'd1);

    // 6/2 with writeback always ready; pass-through checked before the edge
    resp_ready = 1'b1;
    stubLat = 3;
    req_valid = 1'b1; req_a = REC6; req_b = REC2; req_sqrt = 1'b0; req_rm = 3'd0; req_tag = 5'd7;
    #1;
    check("pt_inValid", {64'b0, ds_inValid}, 65'd1);
    check("pt_a", ds_a, REC6);
    check("pt_b", ds_b, REC2);
    check("pt_sqrtOp", {64'b0, ds_sqrtOp}, 65'd0);
    issue(REC6, REC2, 1'b0, 3'd0, 5'd7);
    check("inflight_busy", {64'b0, busy}, 65'd1);
    waitResp(40);
    checkResp("div6_2", REC3, 5'b00000, 5'd7);
    step();
    check("div6_2_pulse", {64'b0, resp_valid}, 65'd0);

    // sqrt(-1) -> invalid
    issue(RECM1, REC0, 1'b1, 3'd0, 5'd3);
    waitResp(40);
    checkResp("sqrtm1", QNAN, 5'b10000, 5'd3);
    step();

    // kill while in flight: no response, busy until the unit reports done
    stubLat = 8;
    issue(REC6, REC2, 1'b0, 3'd0, 5'd11);
    step(2);
    kill = 1'b1;
    step();
    kill = 1'b0;
    check("killed_busy", {64'b0, busy}, 65'd1);
    sawResp = 0;
    n = 0;
    while (busy && n < 40) begin
      if (resp_valid) sawResp++;
      step();
      n++;
    end
    check("killed_idle", {64'b0, busy}, 65'd0);
    check("killed_no_resp", 65'(sawResp), 65'd0);
    stubLat = 1;
    issue(REC1, REC0, 1'b0, 3'd1, 5'd20);
    waitResp(40);
    checkResp("after_kill", RINF, 5'b01000, 5'd20);
    step();

    // 1/0 with writeback stalled for 10 cycles while another request waits
    resp_ready = 1'b0;
    issue(REC1, REC0, 1'b0, 3'd0, 5'd12);
    waitResp(40);
    req_valid = 1'b1; req_a = REC6; req_b = REC2; req_sqrt = 1'b0; req_tag = 5'd9;
    for (int i = 0; i < 10; i++) begin
      #1;
      checkResp("stall", RINF, 5'b01000, 5'd12);
      check("stall_valid", {64'b0, resp_valid}, 65'd1);
      check("stall_req_ready", {64'b0, req_ready}, 65'd0);
      check("stall_inValid", {64'b0, ds_inValid}, 65'd0);
      step();
    end
    resp_ready = 1'b1;
    #1;
    check("hold_exit_no_fire", {64'b0, req_ready}, 65'd0);
    step();
    resp_ready = 1'b0;
    check("next_cycle_ready", {64'b0, req_ready}, 65'd1);
    step();
    req_valid = 1'b0;
    check("next_fired", {64'b0, busy}, 65'd1);
    resp_ready = 1'b1;
    waitResp(40);
    checkResp("queued_req", REC3, 5'b00000, 5'd9);
    step();

    // kill while holding a result drops it
    resp_ready = 1'b0;
    issue(RECM1, REC0, 1'b1, 3'd0, 5'd1);
    waitResp(40);
    kill = 1'b1;
    #1;
    check("kill_blocks_ready", {64'b0, req_ready}, 65'd0);
    step();
    kill = 1'b0;
    check("hold_kill_valid", {64'b0, resp_valid}, 65'd0);
    check("hold_kill_busy", {64'b0, busy}, 65'd0);

    // random operations with random latency and writeback back-pressure
    for (int i = 0; i < 20; i++) begin
      ra = {$urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom};
      rs = 1'($urandom_range(0, 1));
      rt = TAG_W'($urandom);
      stubLat = $urandom_range(0, 6);
      d = $urandom_range(0, 3);
      ex = unitResult(ra, rb, rs);
      resp_ready = 1'b0;
      issue(ra, rb, rs, 3'($urandom), rt);
      waitResp(40);
      checkResp("rand", ex[69:5], ex[4:0], rt);
      repeat (d) begin
        step();
        check("rand_stable", resp_data, ex[69:5]);
      end
      resp_ready = 1'b1;
      step();
      check("rand_release", {64'b0, resp_valid}, 65'd0);
    end
    check("no_err_yet", {64'b0, err}, 65'd0);

    // flavour mismatch: err set, result still captured
    stubSwap = 1'b1;
    stubLat = 2;
    resp_ready = 1'b0;
    issue(REC6, REC2, 1'b0, 3'd0, 5'd5);
    waitResp(40);
    checkResp("mismatch", REC3, 5'b00000, 5'd5);
    check("mismatch_err", {64'b0, err}, 65'd1);
    resp_ready = 1'b1;
    step();
    stubSwap = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("err_cleared", {64'b0, err}, 65'd0);

    // stray done while idle, sticky until reset
    forceOvSqrt = 1'b1;
    step();
    forceOvSqrt = 1'b0;
    check("idle_done_err", {64'b0, err}, 65'd1);
    issue(REC6, REC2, 1'b0, 3'd0, 5'd2);
    waitResp(40);
    step(2);
    check("err_sticky", {64'b0, err}, 65'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkResetState("reset2");

    // timeout: unit never answers
    stubHang = 1'b1;
    resp_ready = 1'b0;
    issue(REC6, REC2, 1'b0, 3'd0, 5'd30);
    step(TIMEOUT - 5);
    check("pre_timeout_err", {64'b0, err}, 65'd0);
    step(10);
    check("timeout_err", {64'b0, err}, 65'd1);
    check("timeout_busy", {64'b0, busy}, 65'd1);
    // leave a non-zero result behind? reset mid-WAIT returns everything to reset values
    reset = 1'b1;
    stubHang = 1'b0;
    step();
    reset = 1'b0;
    checkResetState("reset_midwait");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
